// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: ALU and load unit share the single register_file write port.
// Define WB_RR_EN for round-robin arbitration; default is MEM priority with ALU starvation override.
module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_WIDTH-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  input  logic [ADDR_WIDTH-1:0]      a_select,
  input  logic [ADDR_WIDTH-1:0]      b_select,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [ADDR_WIDTH-1:0]      wr_select,
  output logic                       wr_enable,
  output logic [(1<<ADDR_WIDTH)-1:0] busy,
  output logic                       hazard_a,
  output logic                       hazard_b
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

  logic                  alu_hold_v;
  logic [ADDR_WIDTH-1:0] alu_hold_rd;
  logic [DATA_WIDTH-1:0] alu_hold_data;
  logic                  mem_hold_v;
  logic [ADDR_WIDTH-1:0] mem_hold_rd;
  logic [DATA_WIDTH-1:0] mem_hold_data;

  grant_e                grant;
  logic                  alu_take;
  logic                  mem_take;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clr_mask;

`ifdef WB_RR_EN
  // rr_ptr = 0 favours ALU, 1 favours MEM; it always points away from the last winner.
  logic rr_ptr;

  always_comb begin
    grant = GNT_NONE;
    if (alu_hold_v && mem_hold_v) grant = rr_ptr ? GNT_MEM : GNT_ALU;
    else if (alu_hold_v)          grant = GNT_ALU;
    else if (mem_hold_v)          grant = GNT_MEM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              rr_ptr <= 1'b0;
    else if (grant == GNT_ALU) rr_ptr <= 1'b1;
    else if (grant == GNT_MEM) rr_ptr <= 1'b0;
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             alu_starved;

  assign alu_starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (mem_hold_v && !(alu_hold_v && alu_starved)) grant = GNT_MEM;
    else if (alu_hold_v)                            grant = GNT_ALU;
  end

  // Counts consecutive cycles a waiting ALU entry lost to MEM.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              starve_cnt <= '0;
    else if (!alu_hold_v || grant == GNT_ALU)  starve_cnt <= '0;
    else if (grant == GNT_MEM)                 starve_cnt <= starve_cnt + 1'b1;
  end
`endif

  // A slot accepts when empty or when its current entry drains this cycle.
  assign alu_ready = reset_n && (!alu_hold_v || (grant == GNT_ALU));
  assign mem_ready = reset_n && (!mem_hold_v || (grant == GNT_MEM));
  assign alu_take  = alu_valid && alu_ready;
  assign mem_take  = mem_valid && mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_hold_v <= 1'b0;
      mem_hold_v <= 1'b0;
    end else begin
      if (alu_take)              alu_hold_v <= 1'b1;
      else if (grant == GNT_ALU) alu_hold_v <= 1'b0;
      if (mem_take)              mem_hold_v <= 1'b1;
      else if (grant == GNT_MEM) mem_hold_v <= 1'b0;
    end
  end

  // NOTE: hold payloads are qualified by their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alu_take) begin
      alu_hold_rd   <= alu_rd;
      alu_hold_data <= alu_data;
    end
    if (mem_take) begin
      mem_hold_rd   <= mem_rd;
      mem_hold_data <= mem_data;
    end
  end

  // Registered write port; select/data hold their last values when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_enable <= 1'b0;
      wr_select <= '0;
      wr_data   <= '0;
    end else begin
      unique case (grant)
        GNT_ALU: begin
          wr_enable <= 1'b1;
          wr_select <= alu_hold_rd;
          wr_data   <= alu_hold_data;
        end
        GNT_MEM: begin
          wr_enable <= 1'b1;
          wr_select <= mem_hold_rd;
          wr_data   <= mem_hold_data;
        end
        default: wr_enable <= 1'b0;
      endcase
    end
  end

  // A grant keeps busy set while the other slot still owes a write to the same register.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (grant == GNT_ALU && !(mem_hold_v && mem_hold_rd == alu_hold_rd))
      clr_mask[alu_hold_rd] = 1'b1;
    if (grant == GNT_MEM && !(alu_hold_v && alu_hold_rd == mem_hold_rd))
      clr_mask[mem_hold_rd] = 1'b1;
    if (issue_valid)
      set_mask[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= (busy & ~clr_mask) | set_mask;
  end

  assign hazard_a = busy[a_select];
  assign hazard_b = busy[b_select];

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter; expectations follow WB_RR_EN when defined.
module tb_regfile_writeback_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alu_valid, mem_valid, issue_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, issue_rd, a_select, b_select;
  logic [DW-1:0] alu_data, mem_data;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_select;
  logic          wr_enable;
  logic [15:0]   busy;
  logic          hazard_a, hazard_b;

  int checks_total  = 0;
  int checks_passed = 0;

  regfile_writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .a_select(a_select), .b_select(b_select),
    .wr_data(wr_data), .wr_select(wr_select), .wr_enable(wr_enable),
    .busy(busy), .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd = '0; mem_rd = '0; issue_rd = '0; a_select = '0; b_select = '0;
    alu_data = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks_total++; if (wr_enable !== 1'b0) $display("FAIL rst_wr_enable: got %b want 0", wr_enable); else checks_passed++;
    checks_total++; if (wr_select !== 4'd0) $display("FAIL rst_wr_select: got %0d want 0", wr_select); else checks_passed++;
    checks_total++; if (wr_data !== 32'd0) $display("FAIL rst_wr_data: got %h want 0", wr_data); else checks_passed++;
    checks_total++; if (busy !== 16'h0) $display("FAIL rst_busy: got %h want 0", busy); else checks_passed++;
    checks_total++; if ({alu_ready, mem_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {alu_ready, mem_ready}); else checks_passed++;
    reset_n = 1'b1;
    #1;
    checks_total++; if ({alu_ready, mem_ready} !== 2'b11) $display("FAIL post_rst_ready: got %b want 11", {alu_ready, mem_ready}); else checks_passed++;
    step();
  endtask

  task automatic test_single_alu();
    issue_valid = 1; issue_rd = 4'd7;
    step();
    issue_valid = 0;
    checks_total++; if (busy !== 16'h0080) $display("FAIL alu_issue_busy: got %h want 0080", busy); else checks_passed++;
    alu_valid = 1; alu_rd = 4'd7; alu_data = 32'h0000000B;
    step();
    alu_valid = 0;
    checks_total++; if (wr_enable !== 1'b0) $display("FAIL alu_lat_n: got %b want 0", wr_enable); else checks_passed++;
    checks_total++; if (busy !== 16'h0080) $display("FAIL alu_busy_n: got %h want 0080", busy); else checks_passed++;
    step();
    checks_total++; if (wr_enable !== 1'b1) $display("FAIL alu_wr_en: got %b want 1", wr_enable); else checks_passed++;
    checks_total++; if (wr_select !== 4'd7) $display("FAIL alu_wr_sel: got %0d want 7", wr_select); else checks_passed++;
    checks_total++; if (wr_data !== 32'h0B) $display("FAIL alu_wr_data: got %h want 0000000b", wr_data); else checks_passed++;
    checks_total++; if (busy !== 16'h0) $display("FAIL alu_busy_clr: got %h want 0", busy); else checks_passed++;
    step();
    checks_total++; if (wr_enable !== 1'b0) $display("FAIL alu_one_cycle: got %b want 0", wr_enable); else checks_passed++;
    checks_total++; if ({wr_select, wr_data} !== {4'd7, 32'h0B}) $display("FAIL alu_idle_hold: got %0d/%h want 7/0000000b", wr_select, wr_data); else checks_passed++;
  endtask

  task automatic test_simultaneous();
    logic [3:0]  first_sel, second_sel;
    logic [31:0] first_data, second_data;
    first_sel   = RR ? 4'd3 : 4'd12;
    first_data  = RR ? 32'h0A : 32'h0C;
    second_sel  = RR ? 4'd12 : 4'd3;
    second_data = RR ? 32'h0C : 32'h0A;
    // lone MEM write leaves the round-robin pointer favouring ALU
    mem_valid = 1; mem_rd = 4'd1; mem_data = 32'h11;
    step();
    mem_valid = 0;
    step();
    checks_total++; if ({wr_enable, wr_select} !== {1'b1, 4'd1}) $display("FAIL lone_mem: got %b/%0d want 1/1", wr_enable, wr_select); else checks_passed++;
    alu_valid = 1; alu_rd = 4'd3;  alu_data = 32'h0A;
    mem_valid = 1; mem_rd = 4'd12; mem_data = 32'h0C;
    step();
    alu_valid = 0; mem_valid = 0;
    checks_total++; if ({alu_ready, mem_ready} !== {RR, !RR}) $display("FAIL sim_ready: got %b want %b", {alu_ready, mem_ready}, {RR, !RR}); else checks_passed++;
    step();
    checks_total++; if ({wr_enable, wr_select, wr_data} !== {1'b1, first_sel, first_data}) $display("FAIL sim_first: got %b/%0d/%h want 1/%0d/%h", wr_enable, wr_select, wr_data, first_sel, first_data); else checks_passed++;
    step();
    checks_total++; if ({wr_enable, wr_select, wr_data} !== {1'b1, second_sel, second_data}) $display("FAIL sim_second: got %b/%0d/%h want 1/%0d/%h", wr_enable, wr_select, wr_data, second_sel, second_data); else checks_passed++;
    step();
    checks_total++; if (wr_enable !== 1'b0) $display("FAIL sim_idle: got %b want 0", wr_enable); else checks_passed++;
  endtask

`ifndef WB_RR_EN
  task automatic test_starvation();
    alu_valid = 1; alu_rd = 4'd2; alu_data = 32'h22;
    mem_valid = 1; mem_rd = 4'd8; mem_data = 32'h108;
    step();
    alu_valid = 0;
    for (int k = 0; k < 4; k++) begin
      mem_rd = 4'(9 + k); mem_data = 32'h109 + 32'(k);
      checks_total++; if ({alu_ready, mem_ready} !== 2'b01) $display("FAIL starve_ready_%0d: got %b want 01", k, {alu_ready, mem_ready}); else checks_passed++;
      step();
      checks_total++; if ({wr_enable, wr_select, wr_data} !== {1'b1, 4'(8 + k), 32'h108 + 32'(k)}) $display("FAIL starve_mem_%0d: got %b/%0d/%h want 1/%0d/%h", k, wr_enable, wr_select, wr_data, 8 + k, 32'h108 + 32'(k)); else checks_passed++;
    end
    mem_rd = 4'd13; mem_data = 32'h10D;
    checks_total++; if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL starve_force_ready: got %b want 10", {alu_ready, mem_ready}); else checks_passed++;
    step();
    checks_total++; if ({wr_enable, wr_select, wr_data} !== {1'b1, 4'd2, 32'h22}) $display("FAIL starve_alu: got %b/%0d/%h want 1/2/00000022", wr_enable, wr_select, wr_data); else checks_passed++;
    checks_total++; if (mem_ready !== 1'b1) $display("FAIL starve_mem_ready_back: got %b want 1", mem_ready); else checks_passed++;
    step();
    mem_valid = 0;
    checks_total++; if ({wr_select, wr_data} !== {4'd12, 32'h10C}) $display("FAIL starve_after_12: got %0d/%h want 12/0000010c", wr_select, wr_data); else checks_passed++;
    step();
    checks_total++; if ({wr_enable, wr_select, wr_data} !== {1'b1, 4'd13, 32'h10D}) $display("FAIL starve_after_13: got %b/%0d/%h want 1/13/0000010d", wr_enable, wr_select, wr_data); else checks_passed++;
    step();
    checks_total++; if (wr_enable !== 1'b0) $display("FAIL starve_idle: got %b want 0", wr_enable); else checks_passed++;
  endtask
`endif

  task automatic test_hazard();
    issue_valid = 1; issue_rd = 4'd12; a_select = 4'd12; b_select = 4'd12;
    step();
    issue_valid = 0;
    checks_total++; if ({hazard_a, hazard_b} !== 2'b11) $display("FAIL haz_set: got %b want 11", {hazard_a, hazard_b}); else checks_passed++;
    checks_total++; if (busy !== 16'h1000) $display("FAIL haz_busy: got %h want 1000", busy); else checks_passed++;
    b_select = 4'd3;
    #1;
    checks_total++; if (hazard_b !== 1'b0) $display("FAIL haz_b_other: got %b want 0", hazard_b); else checks_passed++;
    b_select = 4'd12;
    mem_valid = 1; mem_rd = 4'd12; mem_data = 32'hC0;
    step();
    mem_valid = 0;
    checks_total++; if (hazard_a !== 1'b1) $display("FAIL haz_pending: got %b want 1", hazard_a); else checks_passed++;
    issue_valid = 1; issue_rd = 4'd12;
    step();
    issue_valid = 0;
    checks_total++; if ({wr_enable, wr_select} !== {1'b1, 4'd12}) $display("FAIL haz_write: got %b/%0d want 1/12", wr_enable, wr_select); else checks_passed++;
    checks_total++; if ({busy[12], hazard_b} !== 2'b11) $display("FAIL haz_set_wins: got %b want 11", {busy[12], hazard_b}); else checks_passed++;
    mem_valid = 1; mem_rd = 4'd12; mem_data = 32'hC1;
    step();
    mem_valid = 0;
    step();
    checks_total++; if ({busy, hazard_a, hazard_b} !== {16'h0, 2'b00}) $display("FAIL haz_clear: got %h/%b%b want 0000/00", busy, hazard_a, hazard_b); else checks_passed++;
  endtask

  task automatic test_same_rd();
    logic [31:0] first_data, second_data;
    first_data  = RR ? 32'h51 : 32'h52;
    second_data = RR ? 32'h52 : 32'h51;
    issue_valid = 1; issue_rd = 4'd5;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 4'd5; alu_data = 32'h51;
    mem_valid = 1; mem_rd = 4'd5; mem_data = 32'h52;
    step();
    alu_valid = 0; mem_valid = 0;
    step();
    checks_total++; if ({wr_enable, wr_select, wr_data} !== {1'b1, 4'd5, first_data}) $display("FAIL same_first: got %b/%0d/%h want 1/5/%h", wr_enable, wr_select, wr_data, first_data); else checks_passed++;
    checks_total++; if (busy !== 16'h0020) $display("FAIL same_busy_kept: got %h want 0020", busy); else checks_passed++;
    step();
    checks_total++; if ({wr_enable, wr_select, wr_data} !== {1'b1, 4'd5, second_data}) $display("FAIL same_second: got %b/%0d/%h want 1/5/%h", wr_enable, wr_select, wr_data, second_data); else checks_passed++;
    checks_total++; if (busy !== 16'h0) $display("FAIL same_busy_clr: got %h want 0", busy); else checks_passed++;
    step();
    checks_total++; if (wr_enable !== 1'b0) $display("FAIL same_idle: got %b want 0", wr_enable); else checks_passed++;
  endtask

  task automatic test_reset_midstream();
    alu_valid = 1; alu_rd = 4'd1; alu_data = 32'hA1;
    mem_valid = 1; mem_rd = 4'd2; mem_data = 32'hA2;
    issue_valid = 1; issue_rd = 4'd4;
    step();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    step();
    checks_total++; if (wr_enable !== 1'b1) $display("FAIL mid_pre_write: got %b want 1", wr_enable); else checks_passed++;
    reset_n = 1'b0;
    #1;
    checks_total++; if (wr_enable !== 1'b0) $display("FAIL mid_wr_enable: got %b want 0", wr_enable); else checks_passed++;
    checks_total++; if ({wr_select, wr_data} !== {4'd0, 32'd0}) $display("FAIL mid_wr_regs: got %0d/%h want 0/00000000", wr_select, wr_data); else checks_passed++;
    checks_total++; if (busy !== 16'h0) $display("FAIL mid_busy: got %h want 0", busy); else checks_passed++;
    checks_total++; if ({alu_ready, mem_ready} !== 2'b00) $display("FAIL mid_ready: got %b want 00", {alu_ready, mem_ready}); else checks_passed++;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks_total++; if (wr_enable !== 1'b0) $display("FAIL mid_no_write_%0d: got %b want 0", i, wr_enable); else checks_passed++;
    end
    checks_total++; if (busy !== 16'h0) $display("FAIL mid_busy_after: got %h want 0", busy); else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
`ifndef WB_RR_EN
    test_starvation();
`endif
    test_hazard();
    test_same_rd();
    test_reset_midstream();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Arbitrates two writeback sources, the ALU and the memory load unit, onto the single register_file write port (data_in, decoder_control, load_enable). Each source has a one-entry holding register behind a valid/ready handshake. The block also keeps a 16-bit busy scoreboard and flags read hazards on the a_select/b_select read addresses. Sits between execute/memory stages and register_file; the decode stage drives the issue inputs.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 4, register select width (2**ADDR_WIDTH registers)
STARVE_LIMIT, 4, consecutive lost cycles before ALU is force-granted (fixed-priority mode only)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU hold slot can accept
alu_rd  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
mem_valid  in  1  memory writeback request
mem_ready  out  1  memory hold slot can accept
mem_rd  in  ADDR_WIDTH  memory destination register
mem_data  in  DATA_WIDTH  load result
issue_valid  in  1  decode issued an instruction that writes issue_rd
issue_rd  in  ADDR_WIDTH  destination of the issued instruction
a_select  in  ADDR_WIDTH  port A read address (shared with register_file)
b_select  in  ADDR_WIDTH  port B read address (shared with register_file)
wr_data  out  DATA_WIDTH  to register_file data_in
wr_select  out  ADDR_WIDTH  to register_file decoder_control
wr_enable  out  1  to register_file load_enable
busy  out  2**ADDR_WIDTH  scoreboard, bit n = register n has a pending write
hazard_a  out  1  busy[a_select]
hazard_b  out  1  busy[b_select]

Behaviour:
- Reset (reset_n low, async): holds invalid, wr_enable/wr_select/wr_data = 0, busy = 0, starve counter = 0, RR pointer = ALU. alu_ready/mem_ready = 0 while reset_n low.
- Handshake: transfer on the edge where valid && ready. src_ready = !hold_v || (hold granted this cycle), so one source sustains 1 write/cycle.
- Grant is combinational from hold valids. At the next edge the winner's rd/data is loaded into the wr_* registers, wr_enable = 1, and that hold is cleared. With no grant, wr_enable = 0 and wr_data/wr_select keep their values.
- Latency: accepted at edge N, wr_enable high from edge N+1, register_file captures at edge N+2.
- Fixed priority: MEM wins, except that when the ALU hold has lost STARVE_LIMIT consecutive cycles, the ALU is granted. The counter resets on any ALU grant or when the ALU hold is empty.
- Both holds on the same rd: written in grant order over two cycles. The later write lands last.
- Scoreboard: issue_valid sets busy[issue_rd] at the edge. A grant clears busy[rd] unless the other hold also targets rd. Set and clear on the same rd in the same cycle: set wins. Register 0 is writable and tracked like any other.
- hazard_a/hazard_b are purely combinational from busy and the selects.
- Reset mid-operation: pending holds are discarded and wr_enable drops immediately; no partial write is issued after release.

Optional Feature:
WB_RR_EN: when defined, arbitration is round-robin. A one-bit pointer favours the source not granted last; STARVE_LIMIT and the starve counter are unused. When undefined: fixed MEM priority with the starvation override described above.

Test Plan:
- Reset mid-stream: assert reset_n low with both holds full -> wr_enable 0 at once, busy = 0, no write after release.
- Single ALU write: alu_valid with rd=7, data=0x0000000B at edge N -> wr_enable=1, wr_select=7, wr_data=0x0B from edge N+1 for exactly one cycle; busy[7] set by a prior issue clears at the same edge.
- Simultaneous requests: ALU rd=3/0x0A and MEM rd=12/0x0C in the same cycle -> MEM written first, ALU next cycle. With WB_RR_EN after a prior MEM grant -> ALU first.
- Starvation: mem_valid held high with a new rd every cycle, ALU hold full -> ALU granted on cycle 5 (STARVE_LIMIT=4), mem_ready deasserted that cycle.
- Scoreboard hazard: issue rd=12, a_select=b_select=12 -> hazard_a=hazard_b=1 until the rd=12 write is granted. Issue rd=12 again on the grant cycle -> busy[12] stays 1.
- Same-rd collision: both holds target rd=5 -> two consecutive writes, busy[5] clears only after the second.
